// File: rtl/wash_phase_timer.sv
// Phase tracker and watchdog for the washing machine controller: follows the machine
// FSM's valve/motor outputs, times wash/rinse/spin periods and latches fill/drain faults.
module wash_phase_timer #(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned PRESCALE    = 1000,
   parameter int unsigned WASH_TICKS  = 300,
   parameter int unsigned RINSE_TICKS = 180,
   parameter int unsigned SPIN_TICKS  = 240,
   parameter int unsigned FILL_LIMIT  = 600,
   parameter int unsigned DRAIN_LIMIT = 400
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             fill_valve_on,
   input  logic             motor_on,
   input  logic             drained,
   input  logic             done,
   input  logic             abort,
   output logic             cycle_timeout,
   output logic             spin_timeout,
   output logic             fault,
   output logic [1:0]       fault_code,
   output logic [2:0]       phase,
   output logic [CNT_W-1:0] remaining
);

   typedef enum logic [2:0] {
      P_IDLE  = 3'd0,
      P_FILL  = 3'd1,
      P_WASH  = 3'd2,
      P_DRAIN = 3'd3,
      P_SPIN  = 3'd4,
      P_FAULT = 3'd5
   } phase_t;

   localparam int unsigned     PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

   localparam logic [CNT_W-1:0] FILL_LOAD  = CNT_W'(FILL_LIMIT);
   localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_LIMIT);
   localparam logic [CNT_W-1:0] WASH_LOAD  = CNT_W'(WASH_TICKS);
   localparam logic [CNT_W-1:0] RINSE_LOAD = CNT_W'(RINSE_TICKS);
   localparam logic [CNT_W-1:0] SPIN_LOAD  = CNT_W'(SPIN_TICKS);

   localparam longint unsigned CNT_MAX = (64'd1 << CNT_W) - 64'd1;

   if (PRESCALE < 1) begin : g_bad_prescale
      $error("wash_phase_timer: PRESCALE must be at least 1");
   end

   if (WASH_TICKS > CNT_MAX || RINSE_TICKS > CNT_MAX || SPIN_TICKS > CNT_MAX ||
       FILL_LIMIT > CNT_MAX || DRAIN_LIMIT > CNT_MAX) begin : g_bad_ticks
      $error("wash_phase_timer: tick parameter does not fit in CNT_W bits");
   end

   phase_t           state;
   logic             rinse;
   logic [PS_W-1:0]  ps_cnt;
   logic [PS_W-1:0]  ps_next;
   logic             tick;
   logic [CNT_W-1:0] rem_dec;
   logic [CNT_W-1:0] wash_load;

   // The prescaler only advances in the timed/watched phases; IDLE and FAULT hold it at 0.
   assign tick      = (state != P_IDLE) && (state != P_FAULT) && (ps_cnt == PS_LAST);
   assign ps_next   = tick ? '0 : ps_cnt + 1'b1;
   assign rem_dec   = (tick && (remaining != '0)) ? remaining - 1'b1 : remaining;
   assign wash_load = rinse ? RINSE_LOAD : WASH_LOAD;
   assign phase     = state;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= P_IDLE;
         rinse         <= 1'b0;
         ps_cnt        <= '0;
         remaining     <= '0;
         cycle_timeout <= 1'b0;
         spin_timeout  <= 1'b0;
         fault         <= 1'b0;
         fault_code    <= 2'b00;
      end else if (abort) begin
         state         <= P_IDLE;
         rinse         <= 1'b0;
         ps_cnt        <= '0;
         remaining     <= '0;
         cycle_timeout <= 1'b0;
         spin_timeout  <= 1'b0;
         fault         <= 1'b0;
         fault_code    <= 2'b00;
      end else begin
         // NOTE: non-blocking assignments so every branch below sees pre-edge register values.
         case (state)
            P_IDLE: begin
               if (fill_valve_on) begin
                  state     <= P_FILL;
                  rinse     <= 1'b0;
                  remaining <= FILL_LOAD;
                  ps_cnt    <= '0;
               end
            end

            P_FILL: begin
               if (motor_on) begin
                  state         <= P_WASH;
                  remaining     <= wash_load;
                  cycle_timeout <= (wash_load == '0);
                  ps_cnt        <= '0;
               end else if (tick && (rem_dec == '0)) begin
                  state      <= P_FAULT;
                  remaining  <= rem_dec;
                  fault      <= 1'b1;
                  fault_code <= 2'b01;
                  ps_cnt     <= '0;
               end else begin
                  remaining <= rem_dec;
                  ps_cnt    <= ps_next;
               end
            end

            P_WASH: begin
               if (!motor_on) begin
                  state         <= P_DRAIN;
                  remaining     <= DRAIN_LOAD;
                  cycle_timeout <= 1'b0;
                  ps_cnt        <= '0;
               end else begin
                  remaining     <= rem_dec;
                  cycle_timeout <= (rem_dec == '0);
                  ps_cnt        <= ps_next;
               end
            end

            P_DRAIN: begin
               // Sensor progress beats a watchdog expiry landing on the same edge.
               if (drained && rinse) begin
                  state        <= P_SPIN;
                  remaining    <= SPIN_LOAD;
                  spin_timeout <= (SPIN_LOAD == '0);
                  ps_cnt       <= '0;
               end else if (drained) begin
                  state     <= P_FILL;
                  rinse     <= 1'b1;
                  remaining <= FILL_LOAD;
                  ps_cnt    <= '0;
               end else if (tick && (rem_dec == '0)) begin
                  state      <= P_FAULT;
                  remaining  <= rem_dec;
                  fault      <= 1'b1;
                  fault_code <= 2'b10;
                  ps_cnt     <= '0;
               end else begin
                  remaining <= rem_dec;
                  ps_cnt    <= ps_next;
               end
            end

            P_SPIN: begin
               if (done) begin
                  state        <= P_IDLE;
                  rinse        <= 1'b0;
                  remaining    <= '0;
                  spin_timeout <= 1'b0;
                  ps_cnt       <= '0;
               end else begin
                  remaining    <= rem_dec;
                  spin_timeout <= (rem_dec == '0);
                  ps_cnt       <= ps_next;
               end
            end

            P_FAULT: begin
               ps_cnt <= '0;
            end

            default: begin
               state         <= P_IDLE;
               rinse         <= 1'b0;
               ps_cnt        <= '0;
               remaining     <= '0;
               cycle_timeout <= 1'b0;
               spin_timeout  <= 1'b0;
               fault         <= 1'b0;
               fault_code    <= 2'b00;
            end
         endcase
      end
   end

endmodule
